// File: rtl/xy_route_ctrl.sv
// Per-input-port route computation and wormhole lock for a mesh NoC router.
// Routes head flits (XY or YX order), locks the output port until the tail is granted.
module xy_route_ctrl #(
  parameter int unsigned FLIT_W    = 12,
  parameter int unsigned X_W       = 2,
  parameter int unsigned Y_W       = 2,
  parameter int unsigned DEST_LSB  = 8,
  parameter int unsigned TYPE_LSB  = 6,
  parameter int unsigned COLS      = 3,
  parameter int unsigned ROWS      = 3,
  parameter bit          YX_MODE   = 1'b0,
  parameter int unsigned STALL_MAX = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [X_W+Y_W-1:0] id,
  input  logic [FLIT_W-1:0]  flit_in,
  input  logic               empty,
  input  logic               grant,
  output logic [4:0]         outport,
  output logic               rd_en,
  output logic               err_drop,
  output logic               stall
);

  localparam int unsigned ID_W  = X_W + Y_W;
  localparam int unsigned CNT_W = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
  localparam logic [CNT_W-1:0] StallMax = CNT_W'(STALL_MAX);

  localparam logic [4:0] PortLocal = 5'b00001;
  localparam logic [4:0] PortEast  = 5'b00010;
  localparam logic [4:0] PortSouth = 5'b00100;
  localparam logic [4:0] PortWest  = 5'b01000;
  localparam logic [4:0] PortNorth = 5'b10000;

  typedef enum logic [1:0] {
    FtSingle = 2'b00,
    FtHead   = 2'b01,
    FtBody   = 2'b10,
    FtTail   = 2'b11
  } flit_type_e;

  typedef enum logic {
    StIdle,
    StActive
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       port_q, port_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_q, stall_d;
  logic             err_drop_q, err_drop_d;

  flit_type_e       ftype;
  logic [ID_W-1:0]  dest;
  logic [X_W-1:0]   dest_col, id_col;
  logic [Y_W-1:0]   dest_row, id_row;
  logic             is_head;
  logic             is_last;
  logic             dest_in_mesh;
  logic [4:0]       route_port;
  logic             rd_en_c;
  logic             unused_flit_bits;

  assign ftype    = flit_type_e'(flit_in[TYPE_LSB +: 2]);
  assign dest     = flit_in[DEST_LSB +: ID_W];
  assign dest_col = dest[X_W-1:0];
  assign dest_row = dest[ID_W-1:X_W];
  assign id_col   = id[X_W-1:0];
  assign id_row   = id[ID_W-1:X_W];

  // Payload bits are carried by the datapath, not inspected here.
  assign unused_flit_bits = ^flit_in;

  assign is_head      = (ftype == FtSingle) || (ftype == FtHead);
  assign is_last      = (ftype == FtSingle) || (ftype == FtTail);
  assign dest_in_mesh = (32'(dest_col) < COLS) && (32'(dest_row) < ROWS);

  // Dimension-order route; rows grow southward, columns grow eastward.
  always_comb begin
    route_port = PortLocal;
    if (dest == id) begin
      route_port = PortLocal;
    end else if (!YX_MODE) begin
      if (dest_col != id_col) begin
        route_port = (dest_col > id_col) ? PortEast : PortWest;
      end else begin
        route_port = (dest_row > id_row) ? PortSouth : PortNorth;
      end
    end else begin
      if (dest_row != id_row) begin
        route_port = (dest_row > id_row) ? PortSouth : PortNorth;
      end else begin
        route_port = (dest_col > id_col) ? PortEast : PortWest;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    stall_cnt_d = stall_cnt_q;
    err_drop_d  = 1'b0;
    outport     = '0;
    rd_en_c     = 1'b0;

    case (state_q)
      StIdle: begin
        if (!empty) begin
          if (is_head && dest_in_mesh) begin
            port_d  = route_port;
            state_d = StActive;
          end else begin
            // No open packet or unreachable destination: discard the flit.
            rd_en_c    = 1'b1;
            err_drop_d = 1'b1;
          end
        end
      end
      StActive: begin
        outport = empty ? 5'b0 : port_q;
        rd_en_c = grant && !empty;
        if (rd_en_c) begin
          if (is_last) begin
            state_d = StIdle;
            port_d  = '0;
          end
        end else if ((outport != 5'b0) && !grant && (stall_cnt_q != StallMax)) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        port_d  = '0;
      end
    endcase

    // Never pop the FIFO while the block is held in reset.
    rd_en_c = rd_en_c && rst_n;
    if (rd_en_c) begin
      stall_cnt_d = '0;
    end
    stall_d = (stall_cnt_d == StallMax);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      port_q      <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
      err_drop_q  <= err_drop_d;
    end
  end

  assign rd_en    = rd_en_c;
  assign err_drop = err_drop_q;
  assign stall    = stall_q;

endmodule

// File: tb/tb_xy_route_ctrl.sv
// Scoreboard bench for xy_route_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares whenever the DUT shows any activity.
module tb_xy_route_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  id;
  logic [11:0] flit_in;
  logic        empty;
  logic        grant;
  logic [4:0]  outport, outport_yx;
  logic        rd_en, rd_en_yx;
  logic        err_drop, err_drop_yx;
  logic        stall, stall_yx;

  xy_route_ctrl #(
    .YX_MODE  (1'b0),
    .STALL_MAX(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .id      (id),
    .flit_in (flit_in),
    .empty   (empty),
    .grant   (grant),
    .outport (outport),
    .rd_en   (rd_en),
    .err_drop(err_drop),
    .stall   (stall)
  );

  xy_route_ctrl #(
    .YX_MODE(1'b1)
  ) dut_yx (
    .clk     (clk),
    .rst_n   (rst_n),
    .id      (id),
    .flit_in (flit_in),
    .empty   (empty),
    .grant   (grant),
    .outport (outport_yx),
    .rd_en   (rd_en_yx),
    .err_drop(err_drop_yx),
    .stall   (stall_yx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cur_cyc = 0;

  localparam logic [1:0] TSingle = 2'b00;
  localparam logic [1:0] THead   = 2'b01;
  localparam logic [1:0] TBody   = 2'b10;
  localparam logic [1:0] TTail   = 2'b11;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cur_cyc);
    end
  endtask

  // Monitor: compare on any DUT activity or any queued expectation for this cycle.
  always @(negedge clk) begin
    logic [7:0] act;
    exp_t       e;
    act = {outport, rd_en, err_drop, stall};
    if (sb.size() > 0 && sb[0].cyc == cur_cyc) begin
      e = sb.pop_front();
      chk(e.name, act, e.val);
    end else if (act != 8'h0) begin
      chk("unexpected_output", act, 8'h0);
    end
  end

  function automatic logic [11:0] mk(input logic [3:0] dst, input logic [1:0] typ);
    return {dst, typ, 6'h2a};
  endfunction

  task automatic drv(input logic [11:0] f, input logic e, input logic g);
    flit_in = f;
    empty   = e;
    grant   = g;
  endtask

  // Declare expected outputs for the current cycle, then advance one clock.
  task automatic cyc(input string nm, input logic [4:0] op, input logic rd,
                     input logic er, input logic st);
    exp_t x;
    if (op != 5'b0 || rd || er || st) begin
      x.cyc  = cur_cyc;
      x.name = nm;
      x.val  = {op, rd, er, st};
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    cur_cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    id    = 4'b0101;
    drv(12'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    cur_cyc++;
    cyc("reset0", 5'b0, 0, 0, 0);
    cyc("reset1", 5'b0, 0, 0, 0);
    chk("reset_state", {outport, rd_en, err_drop, stall}, 8'h0);
    rst_n = 1'b1;

    // 1: local single flit
    drv(mk(4'b0101, TSingle), 1'b0, 1'b0); cyc("t1_route_lat", 5'b0, 0, 0, 0);
    drv(mk(4'b0101, TSingle), 1'b0, 1'b1); cyc("t1_local_pop", 5'b00001, 1, 0, 0);
    drv(12'h0, 1'b1, 1'b0);                cyc("t1_idle", 5'b0, 0, 0, 0);

    // 2: XY east / YX south, then north
    id = 4'b0000;
    drv(mk(4'b1010, THead), 1'b0, 1'b0);   cyc("t2_lat", 5'b0, 0, 0, 0);
    #1;
    chk("t2_yx_south", outport_yx, 5'b00100);
    cyc("t2_xy_east", 5'b00010, 0, 0, 0);
    drv(mk(4'b1010, TTail), 1'b0, 1'b1);   cyc("t2_east_tail", 5'b00010, 1, 0, 0);
    id = 4'b0110;
    drv(mk(4'b0010, THead), 1'b0, 1'b0);   cyc("t2b_lat", 5'b0, 0, 0, 0);
    #1;
    chk("t2b_yx_north", outport_yx, 5'b10000);
    cyc("t2b_north", 5'b10000, 0, 0, 0);
    drv(mk(4'b0010, TTail), 1'b0, 1'b1);   cyc("t2b_north_tail", 5'b10000, 1, 0, 0);

    // 3: west packet with FIFO gaps and a mid-packet head
    id = 4'b0101;
    drv(mk(4'b0100, THead), 1'b0, 1'b0);   cyc("t3_lat", 5'b0, 0, 0, 0);
    drv(mk(4'b0100, THead), 1'b0, 1'b1);   cyc("t3_head", 5'b01000, 1, 0, 0);
    drv(mk(4'b0100, TBody), 1'b0, 1'b1);   cyc("t3_body1", 5'b01000, 1, 0, 0);
    drv(12'h0, 1'b1, 1'b1);                cyc("t3_gap_grant", 5'b0, 0, 0, 0);
    drv(mk(4'b0101, THead), 1'b0, 1'b0);   cyc("t3_midhead_wait", 5'b01000, 0, 0, 0);
    drv(mk(4'b0101, THead), 1'b0, 1'b1);   cyc("t3_midhead_pop", 5'b01000, 1, 0, 0);
    drv(12'h0, 1'b1, 1'b0);                cyc("t3_gap", 5'b0, 0, 0, 0);
    drv(mk(4'b0100, TTail), 1'b0, 1'b1);   cyc("t3_tail", 5'b01000, 1, 0, 0);
    drv(12'h0, 1'b1, 1'b0);                cyc("t3_idle", 5'b0, 0, 0, 0);

    // 4: malformed and out-of-mesh drops
    drv(mk(4'b0100, TBody), 1'b0, 1'b0);   cyc("t4_body_pop", 5'b0, 1, 0, 0);
    drv(12'h0, 1'b1, 1'b0);                cyc("t4_body_err", 5'b0, 0, 1, 0);
    drv(mk(4'b0011, THead), 1'b0, 1'b0);   cyc("t4_col3_pop", 5'b0, 1, 0, 0);
    drv(12'h0, 1'b1, 1'b0);                cyc("t4_col3_err", 5'b0, 0, 1, 0);
    drv(mk(4'b1100, TSingle), 1'b0, 1'b0); cyc("t4_row3_pop", 5'b0, 1, 0, 0);
    drv(mk(4'b1100, TTail), 1'b0, 1'b0);   cyc("t4_tail_pop", 5'b0, 1, 1, 0);
    drv(12'h0, 1'b1, 1'b0);                cyc("t4_tail_err", 5'b0, 0, 1, 0);

    // 5: stall counter with STALL_MAX=4
    drv(mk(4'b1001, THead), 1'b0, 1'b0);   cyc("t5_lat", 5'b0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc("t5_wait", 5'b00100, 0, 0, 0);
    end
    cyc("t5_stall_on", 5'b00100, 0, 0, 1);
    cyc("t5_stall_hold", 5'b00100, 0, 0, 1);
    drv(mk(4'b1001, THead), 1'b0, 1'b1);   cyc("t5_grant", 5'b00100, 1, 0, 1);
    drv(mk(4'b1001, TTail), 1'b0, 1'b0);   cyc("t5_stall_off", 5'b00100, 0, 0, 0);
    drv(mk(4'b1001, TTail), 1'b0, 1'b1);   cyc("t5_tail", 5'b00100, 1, 0, 0);

    // 6: reset mid-packet
    drv(mk(4'b0100, THead), 1'b0, 1'b0);   cyc("t6_lat", 5'b0, 0, 0, 0);
    drv(mk(4'b0100, THead), 1'b0, 1'b1);   cyc("t6_head", 5'b01000, 1, 0, 0);
    drv(mk(4'b0100, TBody), 1'b0, 1'b0);   cyc("t6_body_wait", 5'b01000, 0, 0, 0);
    rst_n = 1'b0;                          cyc("t6_rst_edge", 5'b01000, 0, 0, 0);
    #1;
    chk("t6_after_reset", {outport, rd_en, err_drop, stall}, 8'h0);
    cyc("t6_in_reset", 5'b0, 0, 0, 0);
    rst_n = 1'b1;                          cyc("t6_orphan_pop", 5'b0, 1, 0, 0);
    drv(12'h0, 1'b1, 1'b0);                cyc("t6_orphan_err", 5'b0, 0, 1, 0);
    cyc("t6_quiet", 5'b0, 0, 0, 0);
    cyc("t6_quiet2", 5'b0, 0, 0, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
